// File: rtl/tick_scheduler.sv
// Per-channel programmable due-event generators sharing one registered service slot.
// Build option SCHED_FIXED_PRIO_EN: fixed priority (lowest index wins) instead of round-robin.
module tick_scheduler #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic              overrun_clr,
    output logic [NUM_CH-1:0] grant,
    output logic              grant_valid,
    output logic [CH_W-1:0]   grant_ch,
    output logic              grant_valid_d,
    output logic [CH_W-1:0]   grant_ch_d,
    output logic [NUM_CH-1:0] overrun
);

    logic [CNT_W-1:0]  period [NUM_CH];
    logic [CNT_W-1:0]  cnt    [NUM_CH];
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] due;
    logic [NUM_CH-1:0] wr_hit;
    logic [NUM_CH-1:0] sel;
    logic              sel_any;
    logic [CH_W-1:0]   sel_ch;

`ifndef SCHED_FIXED_PRIO_EN
    logic [CH_W-1:0]   rr_ptr;
`endif

    // A channel being reprogrammed never raises due in the write cycle.
    always_comb begin
        wr_hit = '0;
        due    = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            wr_hit[i] = cfg_we && (32'(cfg_ch) == i);
            due[i]    = run && !wr_hit[i] && (period[i] != '0) &&
                        (cnt[i] == period[i] - CNT_W'(1));
        end
    end

    always_comb begin
        int unsigned idx;
        idx     = 0;
        sel     = '0;
        sel_any = 1'b0;
        sel_ch  = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
`ifdef SCHED_FIXED_PRIO_EN
            idx = k;
`else
            idx = (32'(rr_ptr) + k) % NUM_CH;
`endif
            if (!sel_any && pending[idx]) begin
                sel_any  = 1'b1;
                sel[idx] = 1'b1;
                sel_ch   = CH_W'(idx);
            end
        end
    end

`ifndef SCHED_FIXED_PRIO_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (sel_any) begin
            rr_ptr <= (32'(sel_ch) + 1 == NUM_CH) ? '0 : sel_ch + CH_W'(1);
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                period[i] <= '0;
                cnt[i]    <= '0;
            end
            pending <= '0;
            overrun <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (wr_hit[i]) begin
                    period[i] <= cfg_period;
                    cnt[i]    <= '0;
                end else if (period[i] == '0) begin
                    cnt[i] <= '0;
                end else if (run) begin
                    cnt[i] <= due[i] ? '0 : cnt[i] + CNT_W'(1);
                end
            end
            // A due arriving on the granting edge re-arms pending rather than being lost.
            pending <= ~wr_hit & (due | (pending & ~sel));
            overrun <= (due & pending & ~sel) | (overrun_clr ? '0 : overrun);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant         <= '0;
            grant_valid   <= 1'b0;
            grant_ch      <= '0;
            grant_valid_d <= 1'b0;
            grant_ch_d    <= '0;
        end else begin
            grant         <= sel;
            grant_valid   <= sel_any;
            grant_ch      <= sel_ch;
            grant_valid_d <= grant_valid;
            grant_ch_d    <= grant_ch;
        end
    end

endmodule
